// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions used by the instruction fetch unit.
//   opcode_t       : 3-bit major opcode held in instruction[2:0]
//   fetch_state_t  : fetch FSM states
//   is_double_word : true for opcodes that carry a 16-bit extension word
package instr_fetch_pkg;

    typedef enum logic [2:0] {
        R_TYPE  = 3'd0,
        I_TYPE  = 3'd1,
        B_TYPE  = 3'd2,
        J_TYPE  = 3'd3,
        M_TYPE  = 3'd4,
        SYS_END = 3'd5
    } opcode_t;

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_HALT
    } fetch_state_t;

    function automatic logic is_double_word(input logic [2:0] opcode);
        return (opcode == I_TYPE) || (opcode == M_TYPE);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the fetch unit's memory bus, redirect input and decode handshake.
//   master : the fetch unit (drives mem request and decode outputs)
//   slave  : the environment (memory, branch unit, decoder)
interface instr_fetch_if;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] instruction;
    logic [15:0] imm;
    logic        has_imm;
    logic [15:0] inst_pc;
    logic        halted;

    modport master (
        output mem_addr, mem_re, inst_valid, instruction, imm, has_imm, inst_pc, halted,
        input  mem_rdata, mem_rvalid, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_addr, mem_re, inst_valid, instruction, imm, has_imm, inst_pc, halted,
        output mem_rdata, mem_rvalid, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch unit.
// Reads one byte per request from an 8-bit memory (one request outstanding),
// assembles a little-endian 16-bit instruction plus an optional 16-bit
// extension word, and presents it to decode with a valid/ready handshake.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : instr_fetch_if.master (memory bus, redirect, decode handshake, halted)
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clock,
    input  logic          reset,
    instr_fetch_if.master bus
);

    fetch_state_t state_reg;
    logic [15:0]  pc_reg;
    logic [1:0]   byte_idx_reg;
    logic         discard_reg;
    logic [15:0]  instruction_reg;
    logic [15:0]  imm_reg;
    logic [15:0]  inst_pc_reg;
    logic         has_imm_reg;
    logic         inst_valid_reg;
    logic         mem_re_reg;
    logic [15:0]  mem_addr_reg;
    logic         halted_reg;

    logic [1:0]   next_byte_idx;
    logic [15:0]  byte_addr;
    logic [15:0]  next_byte_addr;
    logic [15:0]  step_pc;
    logic         redirect_discard;

    assign next_byte_idx  = byte_idx_reg + 2'd1;
    assign byte_addr      = pc_reg + {14'd0, byte_idx_reg};
    assign next_byte_addr = pc_reg + {14'd0, next_byte_idx};
    assign step_pc        = pc_reg + (has_imm_reg ? 16'd4 : 16'd2);

    // A redirect must drop the response of any request still in flight:
    // one issued this cycle, one being waited on, or one already marked
    // for discard. A response arriving in the same cycle is simply ignored,
    // so no flag is needed for it.
    assign redirect_discard = ((state_reg == ST_REQ) && mem_re_reg)
                            || (!bus.mem_rvalid && (discard_reg || (state_reg == ST_WAIT)));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= ST_REQ;
            pc_reg          <= RESET_PC;
            byte_idx_reg    <= 2'd0;
            discard_reg     <= 1'b0;
            instruction_reg <= 16'h0000;
            imm_reg         <= 16'h0000;
            inst_pc_reg     <= 16'h0000;
            has_imm_reg     <= 1'b0;
            inst_valid_reg  <= 1'b0;
            mem_re_reg      <= 1'b0;
            mem_addr_reg    <= 16'h0000;
            halted_reg      <= 1'b0;
        end else if (bus.redirect_valid) begin
            state_reg      <= ST_REQ;
            pc_reg         <= bus.redirect_pc;
            byte_idx_reg   <= 2'd0;
            inst_valid_reg <= 1'b0;
            halted_reg     <= 1'b0;
            discard_reg    <= redirect_discard;
            // Issue straight away unless an old response is still owed.
            mem_re_reg     <= !redirect_discard;
            if (!redirect_discard) begin
                mem_addr_reg <= bus.redirect_pc;
            end
        end else begin
            unique case (state_reg)
                ST_REQ: begin
                    if (mem_re_reg) begin
                        mem_re_reg <= 1'b0;
                        state_reg  <= ST_WAIT;
                    end else if (!discard_reg || bus.mem_rvalid) begin
                        // Strobe not yet issued: first cycle after reset, or
                        // the stale response has just been swallowed.
                        discard_reg  <= 1'b0;
                        mem_re_reg   <= 1'b1;
                        mem_addr_reg <= byte_addr;
                    end
                end

                ST_WAIT: begin
                    if (bus.mem_rvalid) begin
                        unique case (byte_idx_reg)
                            2'd0: begin
                                instruction_reg[7:0] <= bus.mem_rdata;
                                imm_reg              <= 16'h0000;
                                has_imm_reg          <= 1'b0;
                                byte_idx_reg         <= next_byte_idx;
                                mem_re_reg           <= 1'b1;
                                mem_addr_reg         <= next_byte_addr;
                                state_reg            <= ST_REQ;
                            end
                            2'd1: begin
                                instruction_reg[15:8] <= bus.mem_rdata;
                                if (is_double_word(instruction_reg[2:0])) begin
                                    byte_idx_reg <= next_byte_idx;
                                    mem_re_reg   <= 1'b1;
                                    mem_addr_reg <= next_byte_addr;
                                    state_reg    <= ST_REQ;
                                end else begin
                                    inst_valid_reg <= 1'b1;
                                    inst_pc_reg    <= pc_reg;
                                    state_reg      <= ST_HOLD;
                                end
                            end
                            2'd2: begin
                                imm_reg[7:0] <= bus.mem_rdata;
                                byte_idx_reg <= next_byte_idx;
                                mem_re_reg   <= 1'b1;
                                mem_addr_reg <= next_byte_addr;
                                state_reg    <= ST_REQ;
                            end
                            2'd3: begin
                                imm_reg[15:8]  <= bus.mem_rdata;
                                has_imm_reg    <= 1'b1;
                                inst_valid_reg <= 1'b1;
                                inst_pc_reg    <= pc_reg;
                                state_reg      <= ST_HOLD;
                            end
                        endcase
                    end
                end

                ST_HOLD: begin
                    if (bus.inst_ready) begin
                        inst_valid_reg <= 1'b0;
                        byte_idx_reg   <= 2'd0;
                        pc_reg         <= step_pc;
                        if (instruction_reg[2:0] == SYS_END) begin
                            halted_reg <= 1'b1;
                            state_reg  <= ST_HALT;
                        end else begin
                            mem_re_reg   <= 1'b1;
                            mem_addr_reg <= step_pc;
                            state_reg    <= ST_REQ;
                        end
                    end
                end

                ST_HALT: begin
                    // Leaves only through redirect or reset.
                end
            endcase
        end
    end

    assign bus.mem_addr    = mem_addr_reg;
    assign bus.mem_re      = mem_re_reg;
    assign bus.inst_valid  = inst_valid_reg;
    assign bus.instruction = instruction_reg;
    assign bus.imm         = imm_reg;
    assign bus.has_imm     = has_imm_reg;
    assign bus.inst_pc     = inst_pc_reg;
    assign bus.halted      = halted_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: byte memory model with programmable latency,
// scoreboard of expected decoded instructions, and directed segments that
// exercise reset, single/double-word fetch, decode stall, redirect cases,
// halt and address wrap-around.
module tb_instr_fetch;

    typedef struct {
        logic [15:0] ins;
        logic [15:0] imm;
        logic        has;
        logic [15:0] pc;
    } exp_t;

    logic clk;
    logic reset;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(16'h0000)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]  mem [0:65535];
    exp_t        exp_q [$];
    logic [15:0] addr_q [$];
    int          re_cyc_q [$];
    int          lat = 1;
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [15:0] pend_addr = 16'h0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] addr_at(input int i);
        if (i < addr_q.size()) return {16'h0, addr_q[i]};
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int re_cyc_at(input int i);
        if (i < re_cyc_q.size()) return re_cyc_q[i];
        return -1000;
    endfunction

    // Memory responder: one outstanding request, response after lat cycles.
    always @(negedge clk) begin
        bus.mem_rvalid = 1'b0;
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = mem[pend_addr];
                    pend = 1'b0;
                end
            end
            if (bus.mem_re) begin
                pend      = 1'b1;
                pend_cnt  = lat;
                pend_addr = bus.mem_addr;
                addr_q.push_back(bus.mem_addr);
                re_cyc_q.push_back(cyc);
            end
        end
    end

    // Decode-side monitor: one line per accepted instruction.
    always @(negedge clk) begin
        if (!reset && bus.inst_valid && bus.inst_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", {16'h0, bus.inst_pc}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("inst pc=%h ins=%h imm=%h has_imm=%0d", bus.inst_pc, bus.instruction, bus.imm, bus.has_imm);
                check("sb_ins", {16'h0, bus.instruction}, {16'h0, e.ins});
                check("sb_imm", {16'h0, bus.imm}, {16'h0, e.imm});
                check("sb_has_imm", {31'h0, bus.has_imm}, {31'h0, e.has});
                check("sb_pc", {16'h0, bus.inst_pc}, {16'h0, e.pc});
            end
        end
    end

    task automatic push_exp(input logic [15:0] ins, input logic [15:0] imm, input logic has, input logic [15:0] pc);
        exp_t e;
        e.ins = ins; e.imm = imm; e.has = has; e.pc = pc;
        exp_q.push_back(e);
    endtask

    task automatic clear_logs();
        addr_q.delete();
        re_cyc_q.delete();
    endtask

    task automatic wait_valid(input string tag, output int at_cyc);
        int n = 0;
        at_cyc = -1;
        @(negedge clk);
        while (!bus.inst_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.inst_valid) check(tag, 32'h0, 32'h1);
        at_cyc = cyc;
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        @(negedge clk);
        while (!bus.halted && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'h0, bus.halted}, 32'h1);
    endtask

    task automatic do_redirect(input logic [15:0] target);
        @(posedge clk); #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_re"}, {31'h0, bus.mem_re}, 32'h0);
        check({tag, "_mem_addr"}, {16'h0, bus.mem_addr}, 32'h0);
        check({tag, "_inst_valid"}, {31'h0, bus.inst_valid}, 32'h0);
        check({tag, "_halted"}, {31'h0, bus.halted}, 32'h0);
        check({tag, "_instruction"}, {16'h0, bus.instruction}, 32'h0);
        check({tag, "_imm"}, {16'h0, bus.imm}, 32'h0);
        check({tag, "_inst_pc"}, {16'h0, bus.inst_pc}, 32'h0);
        check({tag, "_has_imm"}, {31'h0, bus.has_imm}, 32'h0);
    endtask

    initial begin
        int vc;
        logic [15:0] wrap_addrs [5];

        reset              = 1'b1;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0;
        bus.mem_rvalid     = 1'b0;
        bus.mem_rdata      = 8'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        // 0x0000: R_TYPE A508, 0x0002: SYS_END
        mem[16'h0000] = 8'h08; mem[16'h0001] = 8'hA5;
        mem[16'h0002] = 8'h05; mem[16'h0003] = 8'h00;
        // 0x0010: I_TYPE 2209 + imm 1234, 0x0014: SYS_END
        mem[16'h0010] = 8'h09; mem[16'h0011] = 8'h22;
        mem[16'h0012] = 8'h34; mem[16'h0013] = 8'h12;
        mem[16'h0014] = 8'h05; mem[16'h0015] = 8'h00;
        // 0x0020: M_TYPE low byte whose response must be dropped
        mem[16'h0020] = 8'hFC; mem[16'h0021] = 8'hFF;
        // 0x0040: J_TYPE 7733, 0x0042: SYS_END (skipped by redirect)
        mem[16'h0040] = 8'h33; mem[16'h0041] = 8'h77;
        mem[16'h0042] = 8'h05; mem[16'h0043] = 8'h00;
        // 0x0100: SYS_END
        mem[16'h0100] = 8'h05; mem[16'h0101] = 8'h00;
        // 0xFFFE: M_TYPE 4C04, extension taken from 0x0000/0x0001
        mem[16'hFFFE] = 8'h04; mem[16'hFFFF] = 8'h4C;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");

        // Segment A: single-word fetch from reset, then halt.
        push_exp(16'hA508, 16'h0000, 1'b0, 16'h0000);
        push_exp(16'h0005, 16'h0000, 1'b0, 16'h0002);
        bus.inst_ready = 1'b1;
        clear_logs();
        @(posedge clk); #1;
        reset = 1'b0;
        wait_valid("a_valid_timeout", vc);
        check("a_latency", vc - re_cyc_at(0), 32'd4);
        wait_halt("a_halted");
        check("a_next_addr", addr_at(2), 32'h0002);
        check("a_re_count", addr_q.size(), 32'd4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("halt_mem_re", {31'h0, bus.mem_re}, 32'h0);
        end
        check("halt_inst_valid", {31'h0, bus.inst_valid}, 32'h0);

        // Segment B: redirect out of HALT, stall decode in HOLD.
        bus.inst_ready = 1'b0;
        push_exp(16'h7733, 16'h0000, 1'b0, 16'h0040);
        do_redirect(16'h0040);
        @(negedge clk);
        check("b_halted_clr", {31'h0, bus.halted}, 32'h0);
        check("b_mem_addr", {16'h0, bus.mem_addr}, 32'h0040);
        check("b_mem_re", {31'h0, bus.mem_re}, 32'h1);
        wait_valid("b_valid_timeout", vc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", {31'h0, bus.inst_valid}, 32'h1);
            check("stall_ins", {16'h0, bus.instruction}, 32'h7733);
            check("stall_pc", {16'h0, bus.inst_pc}, 32'h0040);
            check("stall_mem_re", {31'h0, bus.mem_re}, 32'h0);
        end

        // Segment C: redirect coincident with handshake, then a double word.
        push_exp(16'h2209, 16'h1234, 1'b1, 16'h0010);
        push_exp(16'h0005, 16'h0000, 1'b0, 16'h0014);
        @(posedge clk); #1;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0010;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        clear_logs();
        wait_valid("c_valid_timeout", vc);
        check("c_latency", vc - re_cyc_at(0), 32'd8);
        check("c_has_imm", {31'h0, bus.has_imm}, 32'h1);
        check("c_imm", {16'h0, bus.imm}, 32'h1234);
        wait_halt("c_halted");
        check("c_next_pc", addr_at(4), 32'h0014);

        // Segment D: redirect while waiting on a slow response.
        lat = 3;
        clear_logs();
        push_exp(16'h0005, 16'h0000, 1'b0, 16'h0100);
        do_redirect(16'h0020);
        begin
            int n = 0;
            while (!bus.mem_re && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("d_first_re", {31'h0, bus.mem_re}, 32'h1);
        end
        @(posedge clk); #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0100;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        wait_halt("d_halted");
        check("d_addr0", addr_at(0), 32'h0020);
        check("d_addr_after_redirect", addr_at(1), 32'h0100);
        lat = 1;

        // Segment E: double-word fetch across the top of the address space.
        clear_logs();
        push_exp(16'h4C04, 16'hA508, 1'b1, 16'hFFFE);
        push_exp(16'h0005, 16'h0000, 1'b0, 16'h0002);
        do_redirect(16'hFFFE);
        wait_halt("e_halted");
        wrap_addrs[0] = 16'hFFFE; wrap_addrs[1] = 16'hFFFF;
        wrap_addrs[2] = 16'h0000; wrap_addrs[3] = 16'h0001;
        wrap_addrs[4] = 16'h0002;
        for (int i = 0; i < 5; i++) begin
            check("e_wrap_addr", addr_at(i), {16'h0, wrap_addrs[i]});
        end

        // Reset in the middle of operation, then restart from RESET_PC.
        bus.inst_ready = 1'b0;
        do_redirect(16'h0000);
        wait_valid("r_valid_timeout", vc);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("midrst");
        push_exp(16'hA508, 16'h0000, 1'b0, 16'h0000);
        push_exp(16'h0005, 16'h0000, 1'b0, 16'h0002);
        @(posedge clk); #1;
        bus.inst_ready = 1'b1;
        reset = 1'b0;
        wait_halt("r_halted");

        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
